// File: rtl/tim_timeout.sv
// Retriggerable timeout counter driven by the system tick strobes,
// with a watchdog on the 1 us strobe spacing.
module tim_timeout #(
    parameter int CLK_FREQ = 125,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TIM_1US,
    input  logic             TIM_1MS,
    input  logic             TIM_1S,
    input  logic [1:0]       TO_SEL,
    input  logic [CNT_W-1:0] TO_VAL,
    input  logic             TO_START,
    input  logic             TO_KICK,
    input  logic             TO_STOP,
    input  logic             TICK_CLR,
    output logic             TO_BUSY,
    output logic             TO_EXPIRE,
    output logic             TO_EXPIRED,
    output logic [CNT_W-1:0] TO_REMAIN,
    output logic             TICK_ERR
);

    typedef enum logic [1:0] {IDLE, RUN, EXPD} state_t;

    localparam logic [7:0] SP_EXP = CLK_FREQ[7:0];
    localparam logic [7:0] SP_MAX = 8'hFF;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] reload;
    logic [1:0]       sel;
    logic             expire_q, expire_nxt;
    logic             tick;

    logic             armed;
    logic [7:0]       sp;
    logic             tick_err;

    // Reserved select code 3 falls through to the 1 s strobe.
    always_comb begin
        case (sel)
            2'd0:    tick = TIM_1US;
            2'd1:    tick = TIM_1MS;
            default: tick = TIM_1S;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            reload   <= '0;
            sel      <= 2'd0;
            expire_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            expire_q <= expire_nxt;
            if (TO_START) begin
                reload <= TO_VAL;
                sel    <= TO_SEL;
            end
        end
    end

    // Command priority START > STOP > KICK > tick; a kick swallows a coincident tick.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        expire_nxt = 1'b0;
        if (TO_START) begin
            cnt_nxt = TO_VAL;
            if (TO_VAL != '0) begin
                state_nxt = RUN;
            end else begin
                state_nxt  = EXPD;
                expire_nxt = 1'b1;
            end
        end else if (TO_STOP) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == RUN) begin
            if (TO_KICK) begin
                cnt_nxt = reload;
            end else if (tick) begin
                if (cnt == CNT_W'(1)) begin
                    cnt_nxt    = '0;
                    state_nxt  = EXPD;
                    expire_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        TO_BUSY    = (state == RUN);
        TO_EXPIRED = (state == EXPD);
        TO_EXPIRE  = expire_q;
        TO_REMAIN  = cnt;
        TICK_ERR   = tick_err;
    end

    // The first strobe only arms the monitor, so a short first period is tolerated.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed    <= 1'b0;
            sp       <= '0;
            tick_err <= 1'b0;
        end else if (TICK_CLR) begin
            armed    <= 1'b0;
            sp       <= '0;
            tick_err <= 1'b0;
        end else if (!armed) begin
            if (TIM_1US) begin
                armed <= 1'b1;
                sp    <= 8'd1;
            end
        end else if (TIM_1US) begin
            if (sp != SP_EXP) begin
                tick_err <= 1'b1;
            end
            sp <= 8'd1;
        end else begin
            if (sp == SP_EXP) begin
                tick_err <= 1'b1;
            end
            if (sp != SP_MAX) begin
                sp <= sp + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tim_timeout.sv
// Self-checking bench for tim_timeout: vector table, directed corner sequences
// and a randomized run compared against a behavioural model.
module tb_tim_timeout;

    localparam int CLK_FREQ = 125;
    localparam int CNT_W    = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             TIM_1US, TIM_1MS, TIM_1S;
    logic [1:0]       TO_SEL;
    logic [CNT_W-1:0] TO_VAL;
    logic             TO_START, TO_KICK, TO_STOP, TICK_CLR;
    logic             TO_BUSY, TO_EXPIRE, TO_EXPIRED, TICK_ERR;
    logic [CNT_W-1:0] TO_REMAIN;

    always #5 CLK = ~CLK;

    tim_timeout #(.CLK_FREQ(CLK_FREQ), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .TIM_1US(TIM_1US), .TIM_1MS(TIM_1MS), .TIM_1S(TIM_1S),
        .TO_SEL(TO_SEL), .TO_VAL(TO_VAL),
        .TO_START(TO_START), .TO_KICK(TO_KICK), .TO_STOP(TO_STOP),
        .TICK_CLR(TICK_CLR),
        .TO_BUSY(TO_BUSY), .TO_EXPIRE(TO_EXPIRE), .TO_EXPIRED(TO_EXPIRED),
        .TO_REMAIN(TO_REMAIN), .TICK_ERR(TICK_ERR)
    );

    typedef struct {
        logic        start, stop, kick;
        logic [1:0]  sel;
        logic [15:0] val;
        logic        ms, s;
        logic        busy, expire, expired;
        logic [15:0] remain;
    } tvec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: plain flags and integer arithmetic
    bit      m_busy, m_expire, m_expired, m_err, m_armed;
    int      m_remain, m_reload, m_sel;
    longint  m_cycle, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_expire = 0; m_expired = 0; m_err = 0; m_armed = 0;
        m_remain = 0; m_reload = 0; m_sel = 0; m_last = 0;
    endtask

    task automatic model_update();
        bit     tk;
        longint d;
        m_cycle++;
        if (RST) begin
            model_reset();
            return;
        end
        tk = (m_sel == 0) ? TIM_1US : (m_sel == 1) ? TIM_1MS : TIM_1S;
        m_expire = 0;
        if (TO_START) begin
            m_reload  = int'(TO_VAL);
            m_sel     = int'(TO_SEL);
            m_remain  = int'(TO_VAL);
            m_busy    = (TO_VAL != 0);
            m_expired = (TO_VAL == 0);
            m_expire  = (TO_VAL == 0);
        end else if (TO_STOP) begin
            m_busy = 0; m_expired = 0; m_remain = 0;
        end else if (m_busy) begin
            if (TO_KICK) begin
                m_remain = m_reload;
            end else if (tk) begin
                m_remain = m_remain - 1;
                if (m_remain == 0) begin
                    m_busy = 0; m_expired = 1; m_expire = 1;
                end
            end
        end
        if (TICK_CLR) begin
            m_armed = 0; m_err = 0;
        end else if (!m_armed) begin
            if (TIM_1US) begin
                m_armed = 1; m_last = m_cycle;
            end
        end else begin
            d = m_cycle - m_last;
            if (TIM_1US) begin
                if (d != CLK_FREQ) m_err = 1;
                m_last = m_cycle;
            end else if (d == CLK_FREQ) begin
                m_err = 1;
            end
        end
    endtask

    task automatic compare_model();
        chk("busy",    TO_BUSY,    m_busy);
        chk("expire",  TO_EXPIRE,  m_expire);
        chk("expired", TO_EXPIRED, m_expired);
        chk("remain",  TO_REMAIN,  m_remain[15:0]);
        chk("tickerr", TICK_ERR,   m_err);
    endtask

    task automatic clear_inputs();
        TIM_1US = 0; TIM_1MS = 0; TIM_1S = 0;
        TO_START = 0; TO_KICK = 0; TO_STOP = 0; TICK_CLR = 0;
    endtask

    task automatic clk_step();
        @(posedge CLK);
        model_update();
        #1;
        compare_model();
        clear_inputs();
    endtask

    // gap-1 quiet cycles, then one cycle carrying the 1 us strobe
    task automatic us_gap(input int gap, input bit kick_last);
        for (int i = 0; i < gap - 1; i++) clk_step();
        TIM_1US = 1;
        TO_KICK = kick_last;
        clk_step();
    endtask

    tvec_t tv[19];

    initial begin
        int us_cnt, cur_gap;

        tv[0]  = '{1,0,0, 2'd1, 16'd3, 0,0, 1,0,0, 16'd3};
        tv[1]  = '{0,0,0, 2'd0, 16'd0, 1,0, 1,0,0, 16'd2};
        tv[2]  = '{0,0,0, 2'd0, 16'd0, 0,0, 1,0,0, 16'd2};
        tv[3]  = '{0,0,1, 2'd0, 16'd0, 1,0, 1,0,0, 16'd3};
        tv[4]  = '{0,0,0, 2'd0, 16'd0, 1,0, 1,0,0, 16'd2};
        tv[5]  = '{0,0,0, 2'd0, 16'd0, 0,1, 1,0,0, 16'd2};
        tv[6]  = '{0,0,0, 2'd0, 16'd0, 1,0, 1,0,0, 16'd1};
        tv[7]  = '{0,0,0, 2'd0, 16'd0, 1,0, 0,1,1, 16'd0};
        tv[8]  = '{0,0,0, 2'd0, 16'd0, 0,0, 0,0,1, 16'd0};
        tv[9]  = '{0,0,1, 2'd0, 16'd0, 1,0, 0,0,1, 16'd0};
        tv[10] = '{1,1,0, 2'd2, 16'd5, 0,0, 1,0,0, 16'd5};
        tv[11] = '{0,0,0, 2'd0, 16'd0, 0,1, 1,0,0, 16'd4};
        tv[12] = '{0,1,0, 2'd0, 16'd0, 0,0, 0,0,0, 16'd0};
        tv[13] = '{0,0,1, 2'd0, 16'd0, 0,0, 0,0,0, 16'd0};
        tv[14] = '{1,0,0, 2'd0, 16'd0, 0,0, 0,1,1, 16'd0};
        tv[15] = '{0,0,0, 2'd0, 16'd0, 0,0, 0,0,1, 16'd0};
        tv[16] = '{1,0,0, 2'd0, 16'd0, 0,0, 0,1,1, 16'd0};
        tv[17] = '{0,1,0, 2'd0, 16'd0, 0,0, 0,0,0, 16'd0};
        tv[18] = '{0,0,0, 2'd0, 16'd0, 1,1, 0,0,0, 16'd0};

        m_cycle = 0;
        model_reset();
        clear_inputs();
        TO_SEL = 0; TO_VAL = 0;
        RST = 1;
        #1;
        chk("rst_busy", TO_BUSY, 0);
        chk("rst_remain", TO_REMAIN, 0);
        clk_step();
        clk_step();
        RST = 0;
        clk_step();
        chk("rst_expired", TO_EXPIRED, 0);
        chk("rst_tickerr", TICK_ERR, 0);

        // Command vectors on the 1 ms / 1 s strobes
        for (int i = 0; i < 19; i++) begin
            TO_START = tv[i].start; TO_STOP = tv[i].stop; TO_KICK = tv[i].kick;
            TO_SEL = tv[i].sel; TO_VAL = tv[i].val;
            TIM_1MS = tv[i].ms; TIM_1S = tv[i].s;
            clk_step();
            chk($sformatf("vec%0d_busy", i),    TO_BUSY,    tv[i].busy);
            chk($sformatf("vec%0d_expire", i),  TO_EXPIRE,  tv[i].expire);
            chk($sformatf("vec%0d_expired", i), TO_EXPIRED, tv[i].expired);
            chk($sformatf("vec%0d_remain", i),  TO_REMAIN,  tv[i].remain);
        end

        // Three-tick timeout on the 1 us strobe
        us_gap(1, 0);
        TO_START = 1; TO_VAL = 3; TO_SEL = 0;
        clk_step();
        chk("t1_remain3", TO_REMAIN, 3);
        chk("t1_busy", TO_BUSY, 1);
        us_gap(124, 0);
        chk("t1_remain2", TO_REMAIN, 2);
        us_gap(125, 0);
        chk("t1_remain1", TO_REMAIN, 1);
        us_gap(125, 0);
        chk("t1_expire", TO_EXPIRE, 1);
        chk("t1_busy_low", TO_BUSY, 0);
        chk("t1_expired", TO_EXPIRED, 1);
        chk("t1_remain0", TO_REMAIN, 0);
        clk_step();
        chk("t1_expire_pulse", TO_EXPIRE, 0);
        chk("t1_expired_sticky", TO_EXPIRED, 1);

        // Kick coincident with a tick reloads without decrementing
        TO_START = 1; TO_VAL = 4; TO_SEL = 0;
        clk_step();
        us_gap(123, 0);
        chk("t2_remain3", TO_REMAIN, 3);
        us_gap(125, 0);
        chk("t2_remain2", TO_REMAIN, 2);
        us_gap(125, 1);
        chk("t2_kick_reload", TO_REMAIN, 4);
        us_gap(125, 0);
        us_gap(125, 0);
        us_gap(125, 0);
        chk("t2_remain1", TO_REMAIN, 1);
        chk("t2_no_expire_yet", TO_EXPIRE, 0);
        us_gap(125, 0);
        chk("t2_expire", TO_EXPIRE, 1);
        chk("t2_tickerr_quiet", TICK_ERR, 0);

        // Strobe spacing monitor
        TICK_CLR = 1;
        clk_step();
        us_gap(3, 0);
        us_gap(125, 0);
        us_gap(125, 0);
        chk("t5_good_spacing", TICK_ERR, 0);
        us_gap(124, 0);
        chk("t5_short_spacing", TICK_ERR, 1);
        TICK_CLR = 1;
        clk_step();
        chk("t5_cleared", TICK_ERR, 0);
        us_gap(7, 0);
        us_gap(125, 0);
        chk("t5_good_after_clr", TICK_ERR, 0);
        for (int i = 0; i < 124; i++) clk_step();
        chk("t5_before_missing", TICK_ERR, 0);
        clk_step();
        chk("t5_missing_tick", TICK_ERR, 1);

        // Asynchronous reset while running on 1 ms ticks
        TO_START = 1; TO_VAL = 3; TO_SEL = 1;
        clk_step();
        TIM_1MS = 1;
        clk_step();
        chk("t6_remain2", TO_REMAIN, 2);
        #2 RST = 1;
        #1;
        chk("t6_async_busy", TO_BUSY, 0);
        chk("t6_async_expire", TO_EXPIRE, 0);
        chk("t6_async_expired", TO_EXPIRED, 0);
        chk("t6_async_remain", TO_REMAIN, 0);
        chk("t6_async_tickerr", TICK_ERR, 0);
        clk_step();
        clk_step();
        RST = 0;
        for (int i = 0; i < 3; i++) begin
            TIM_1MS = 1;
            clk_step();
            chk("t6_idle_busy", TO_BUSY, 0);
            chk("t6_idle_remain", TO_REMAIN, 0);
        end

        // Randomized traffic against the model
        us_cnt = 0;
        cur_gap = 125;
        for (int c = 0; c < 3000; c++) begin
            us_cnt++;
            if (us_cnt >= cur_gap) begin
                TIM_1US = 1;
                us_cnt = 0;
                cur_gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 130)) : 125;
            end
            TIM_1MS  = ($urandom_range(0, 6) == 0);
            TIM_1S   = ($urandom_range(0, 22) == 0);
            TO_START = ($urandom_range(0, 59) == 0);
            TO_STOP  = ($urandom_range(0, 149) == 0);
            TO_KICK  = ($urandom_range(0, 39) == 0);
            TICK_CLR = ($urandom_range(0, 399) == 0);
            TO_SEL   = 2'($urandom_range(0, 3));
            TO_VAL   = 16'($urandom_range(0, 6));
            clk_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
